// File: rtl/dmem_lsu.sv
// Load/store requester between the MEM stage and a word-addressed, one-cycle-read dmem.
// Define LSU_SUBWORD_EN to build byte/half loads and read-modify-write sub-word stores.
module dmem_lsu #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic          ReqWrite,
    input  logic [1:0]    ReqSize,
    input  logic          ReqUnsigned,
    input  logic [AW-1:0] ReqAddr,
    input  logic [DW-1:0] ReqWData,
    output logic          RespValid,
    output logic [DW-1:0] RespData,
    output logic          RespErr,
    output logic          MemWE,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    typedef enum logic [1:0] {StIdle, StLoadWait, StRmwWait} state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] req_word_addr;
    logic          accept;
    logic          req_err;
    logic          issue;
    logic [DW-1:0] load_data;

    assign ReqReady      = (state_q == StIdle);
    assign accept        = ReqValid & ReqReady;
    assign req_word_addr = {ReqAddr[AW-1:2], 2'b00};
    assign issue         = accept & ~req_err;

`ifdef LSU_SUBWORD_EN
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] shifted;
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] lane_data;
    logic [DW-1:0] merged;

    always_comb begin
        case (ReqSize)
            2'b00:   req_err = |ReqAddr[1:0];
            2'b01:   req_err = ReqAddr[0];
            2'b10:   req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
    end

    // Halves are always 2-byte aligned, so the byte-offset shift covers both sizes.
    assign shifted   = MemRData >> {off_q, 3'b000};
    assign lane_mask = ((size_q == 2'b10) ? 32'h0000_00ff : 32'h0000_ffff) << {off_q, 3'b000};
    assign lane_data = wdata_q << {off_q, 3'b000};
    assign merged    = (MemRData & ~lane_mask) | (lane_data & lane_mask);

    always_comb begin
        case (size_q)
            2'b10:   load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_data = MemRData;
        endcase
    end
`else
    logic unused_ok;

    assign req_err   = (ReqSize != 2'b00) | (|ReqAddr[1:0]);
    assign load_data = MemRData;
    assign unused_ok = ReqUnsigned;
`endif

    always_comb begin
        MemWE    = 1'b0;
        MemAddr  = addr_q;
        MemWData = ReqWData;
        if (state_q == StIdle) begin
            if (issue) begin
                MemAddr = req_word_addr;
                MemWE   = ReqWrite & (ReqSize == 2'b00);
            end
        end
`ifdef LSU_SUBWORD_EN
        else if (state_q == StRmwWait) begin
            MemWE    = 1'b1;
            MemWData = merged;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            RespValid <= 1'b0;
            RespData  <= '0;
            RespErr   <= 1'b0;
`ifdef LSU_SUBWORD_EN
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
`endif
        end else begin
            RespValid <= 1'b0;
            RespErr   <= 1'b0;
            RespData  <= '0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (req_err) begin
                            RespValid <= 1'b1;
                            RespErr   <= 1'b1;
                        end else begin
                            addr_q <= req_word_addr;
                            if (ReqWrite && ReqSize == 2'b00) begin
                                RespValid <= 1'b1;
                            end else begin
`ifdef LSU_SUBWORD_EN
                                off_q   <= ReqAddr[1:0];
                                size_q  <= ReqSize;
                                uns_q   <= ReqUnsigned;
                                wdata_q <= ReqWData;
                                state_q <= ReqWrite ? StRmwWait : StLoadWait;
`else
                                state_q <= StLoadWait;
`endif
                            end
                        end
                    end
                end
                StLoadWait: begin
                    RespValid <= 1'b1;
                    RespData  <= load_data;
                    state_q   <= StIdle;
                end
                StRmwWait: begin
                    RespValid <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu with a byte-lane reference model and a
// one-cycle registered dmem; follows LSU_SUBWORD_EN to match the build.
module tb_dmem_lsu;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespErr;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    logic [31:0] dmem      [64];
    logic [31:0] model_mem [64];

    int total = 0;
    int bad   = 0;

    dmem_lsu #(.AW(32), .DW(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqSize    (ReqSize),
        .ReqUnsigned(ReqUnsigned),
        .ReqAddr    (ReqAddr),
        .ReqWData   (ReqWData),
        .RespValid  (RespValid),
        .RespData   (RespData),
        .RespErr    (RespErr),
        .MemWE      (MemWE),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRData   (MemRData)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MemWE) dmem[MemAddr[7:2]] <= MemWData;
        MemRData <= dmem[MemAddr[7:2]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b00) return a[1:0] != 2'b00;
        if (!SUB) return 1'b1;
        if (sz == 2'b01) return a[0];
        return 1'b0;
    endfunction

    // One complete transaction with its own inline checks against the model.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit          err;
        int          idx;
        int          sh;
        logic [31:0] old_w, new_w, exp_data, v;
        idx      = int'(a[7:2]);
        err      = model_err(sz, a);
        old_w    = model_mem[idx];
        new_w    = old_w;
        exp_data = 32'h0;
        if (!err) begin
            if (sz == 2'b01) sh = 16 * int'(a[1]);
            else             sh = 8 * int'(a[1:0]);
            if (wr) begin
                if (sz == 2'b00)      new_w = wd;
                else if (sz == 2'b01) new_w = (old_w & ~(32'hffff << sh)) | ((wd & 32'hffff) << sh);
                else                  new_w = (old_w & ~(32'hff << sh)) | ((wd & 32'hff) << sh);
            end else begin
                if (sz == 2'b00) exp_data = old_w;
                else if (sz == 2'b01) begin
                    v = (old_w >> sh) & 32'hffff;
                    if (!uns && v[15]) v = v | 32'hffff_0000;
                    exp_data = v;
                end else begin
                    v = (old_w >> sh) & 32'hff;
                    if (!uns && v[7]) v = v | 32'hffff_ff00;
                    exp_data = v;
                end
            end
        end

        @(negedge CLK);
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns;
        ReqAddr = a; ReqWData = wd;
        #1;
        total++;
        if (ReqReady !== 1'b1) begin
            bad++; $display("FAIL %s ready: got %b want 1", tag, ReqReady);
        end
        total++;
        if (MemWE !== (wr && !err && sz == 2'b00)) begin
            bad++; $display("FAIL %s accept_we: got %b want %b", tag, MemWE, wr && !err && sz == 2'b00);
        end
        if (!err) begin
            total++;
            if (MemAddr !== {a[31:2], 2'b00}) begin
                bad++; $display("FAIL %s addr: got %h want %h", tag, MemAddr, {a[31:2], 2'b00});
            end
        end
        if (wr && !err && sz == 2'b00) begin
            total++;
            if (MemWData !== wd) begin
                bad++; $display("FAIL %s wdata: got %h want %h", tag, MemWData, wd);
            end
        end

        @(posedge CLK); #1;
        ReqValid = 1'b0;
        if (!err) model_mem[idx] = new_w;

        if (err || (wr && sz == 2'b00)) begin
            total++;
            if (RespValid !== 1'b1 || RespErr !== err || RespData !== 32'h0) begin
                bad++;
                $display("FAIL %s resp1: got v=%b e=%b d=%h want v=1 e=%b d=0",
                         tag, RespValid, RespErr, RespData, err);
            end
        end else begin
            total++;
            if (RespValid !== 1'b0 || ReqReady !== 1'b0) begin
                bad++; $display("FAIL %s wait: got v=%b rdy=%b want v=0 rdy=0", tag, RespValid, ReqReady);
            end
            total++;
            if (MemWE !== wr) begin
                bad++; $display("FAIL %s wait_we: got %b want %b", tag, MemWE, wr);
            end
            if (wr) begin
                total++;
                if (MemWData !== new_w || MemAddr !== {a[31:2], 2'b00}) begin
                    bad++; $display("FAIL %s rmw: got %h@%h want %h@%h",
                                    tag, MemWData, MemAddr, new_w, {a[31:2], 2'b00});
                end
            end
            @(posedge CLK); #1;
            total++;
            if (RespValid !== 1'b1 || RespErr !== 1'b0 || RespData !== exp_data) begin
                bad++;
                $display("FAIL %s resp2: got v=%b e=%b d=%h want v=1 e=0 d=%h",
                         tag, RespValid, RespErr, RespData, exp_data);
            end
        end

        @(posedge CLK); #1;
        total++;
        if (RespValid !== 1'b0 || RespErr !== 1'b0 || MemWE !== 1'b0) begin
            bad++; $display("FAIL %s pulse: got v=%b e=%b we=%b want 0 0 0", tag, RespValid, RespErr, MemWE);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
        ReqAddr = 32'h0; ReqWData = 32'h0;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = $urandom;
            model_mem[i] = dmem[i];
        end
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (RespValid !== 1'b0 || RespErr !== 1'b0 || RespData !== 32'h0 || MemWE !== 1'b0) begin
            bad++; $display("FAIL reset_out: got v=%b e=%b d=%h we=%b want 0 0 0 0",
                            RespValid, RespErr, RespData, MemWE);
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total++;
        if (ReqReady !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", ReqReady);
        end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hdead_beef, "word_store");
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "word_load");
        total++;
        if (dmem[4] !== 32'hdead_beef) begin
            bad++; $display("FAIL word_mem: got %h want deadbeef", dmem[4]);
        end
    endtask

    task automatic test_error();
        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "misaligned_load");
        do_req(1'b1, 2'b11, 1'b0, 32'h30, 32'h1234_5678, "reserved_store");
        do_req(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, "odd_half_load");
    endtask

    task automatic test_subword();
        do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h1122_3344, "init_20");
        if (SUB) begin
            do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h0000_00ab, "byte_store");
            total++;
            if (dmem[8] !== 32'h1122_ab44) begin
                bad++; $display("FAIL byte_store_mem: got %h want 1122ab44", dmem[8]);
            end
            do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, "byte_load_s");
            do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, "half_load_u");
        end else begin
            do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, "byte_load_off");
            do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h0000_00ab, "byte_store_off");
            total++;
            if (dmem[8] !== 32'h1122_3344) begin
                bad++; $display("FAIL byte_off_mem: got %h want 11223344", dmem[8]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2;
        a1 = 32'($urandom_range(0, 63) * 4);
        a2 = 32'($urandom_range(0, 63) * 4);
        @(negedge CLK);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b00; ReqAddr = a1;
        @(posedge CLK); #1;
        total++;
        if (ReqReady !== 1'b0 || RespValid !== 1'b0) begin
            bad++; $display("FAIL b2b_wait1: got rdy=%b v=%b want 0 0", ReqReady, RespValid);
        end
        ReqAddr = a2;
        @(posedge CLK); #1;
        total++;
        if (RespValid !== 1'b1 || RespData !== model_mem[a1[7:2]] || ReqReady !== 1'b1) begin
            bad++; $display("FAIL b2b_resp1: got v=%b d=%h rdy=%b want 1 %h 1",
                            RespValid, RespData, ReqReady, model_mem[a1[7:2]]);
        end
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        total++;
        if (RespValid !== 1'b0 || ReqReady !== 1'b0) begin
            bad++; $display("FAIL b2b_wait2: got v=%b rdy=%b want 0 0", RespValid, ReqReady);
        end
        @(posedge CLK); #1;
        total++;
        if (RespValid !== 1'b1 || RespData !== model_mem[a2[7:2]]) begin
            bad++; $display("FAIL b2b_resp2: got v=%b d=%h want 1 %h",
                            RespValid, RespData, model_mem[a2[7:2]]);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
                   $urandom, "random");
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge CLK);
        ReqValid = 1'b1; ReqUnsigned = 1'b0; ReqAddr = SUB ? 32'h21 : 32'h20;
        ReqWrite = SUB; ReqSize = SUB ? 2'b10 : 2'b00; ReqWData = 32'h0000_005a;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        RST = 1'b0;
        #1;
        total++;
        if (MemWE !== 1'b0) begin
            bad++; $display("FAIL rst_mid_we: got %b want 0", MemWE);
        end
        @(posedge CLK); #1;
        total++;
        if (RespValid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_resp: got %b want 0", RespValid);
        end
        total++;
        if (dmem[8] !== model_mem[8]) begin
            bad++; $display("FAIL rst_mid_mem: got %h want %h", dmem[8], model_mem[8]);
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_ready: got rdy=%b v=%b want 1 0", ReqReady, RespValid);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, "after_reset_load");
    endtask

    task automatic test_mem_final();
        int diffs;
        int first;
        diffs = 0;
        first = -1;
        for (int i = 0; i < 64; i++) begin
            if (dmem[i] !== model_mem[i]) begin
                diffs++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (diffs != 0) begin
            bad++; $display("FAIL mem_final: got %0d differing words (first %0d) want 0", diffs, first);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_error();
        test_subword();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_mem_final();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
